// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_core_arbiter
//  Brief    : Round-robin sharing of one AES core between NREQ requesters.
//             Captures the winner's key/plaintext, pulses core_ld, waits for
//             core_done and hands the ciphertext back over valid/ack.
//  Options  : AES_ARB_TIMEOUT_EN - adds a WAIT watchdog that answers with
//             rsp_err=1 / rsp_data=0 once TIMEOUT WAIT cycles have elapsed.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_core_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*128-1:0] req_key,
    input  logic [NREQ*128-1:0] req_text,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ack,
    output logic [127:0]        rsp_data,
    output logic                rsp_err,
    output logic                core_ld,
    output logic [127:0]        core_key,
    output logic [127:0]        core_text,
    input  logic                core_done,
    input  logic [127:0]        core_text_out,
    output logic                busy
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] r_owner;

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic              w_any;
    logic [c_IW-1:0]   w_off;
    logic [c_IW:0]     w_sum;
    logic [c_IW-1:0]   w_win;
    logic [NREQ-1:0]   w_win_oh;
    logic [NREQ-1:0]   w_own_oh;
    logic [127:0]      w_win_key;
    logic [127:0]      w_win_text;
    logic [c_IW-1:0]   w_next_ptr;
    logic              w_expire;

    // Parameter range guard, evaluated at elaboration.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 256) begin : g_param_check
        $error("aes_core_arbiter: NREQ must be 2..8 and TIMEOUT 2..256");
    end

    // Rotate requests so bit 0 is the requester at the round-robin pointer.
    assign w_req2 = {req, req} >> r_ptr;
    assign w_rot  = w_req2[NREQ-1:0];
    assign w_any  = |w_rot;

    // Lowest set bit of the rotated vector is the offset of the winner.
    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_IW'(k);
            end
        end
    end

    // Undo the rotation: winner = (ptr + offset) mod NREQ.
    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = (w_sum >= (c_IW+1)'(NREQ)) ? c_IW'(w_sum - (c_IW+1)'(NREQ))
                                              : c_IW'(w_sum);

    // One-hot decodes of the arbitration winner and the current owner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign w_win_oh[gi] = (w_win   == c_IW'(gi));
        assign w_own_oh[gi] = (r_owner == c_IW'(gi));
    end

    // Select the winner's operand slices.
    always_comb begin
        w_win_key  = '0;
        w_win_text = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_IW'(i)) begin
                w_win_key  = req_key[128*i +: 128];
                w_win_text = req_text[128*i +: 128];
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    assign w_next_ptr = (r_owner == c_IW'(NREQ - 1)) ? '0 : r_owner + c_IW'(1);

`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [7:0] c_WDOG_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wdog;

    // Watchdog: zeroed while loading so the first WAIT cycle counts as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_LOAD) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_expire = (r_state == S_WAIT) && (r_wdog == c_WDOG_LAST);
`else
    assign w_expire = 1'b0;
`endif

    // Main transaction FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            gnt       <= '0;
            core_ld   <= 1'b0;
            core_key  <= '0;
            core_text <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gnt     <= '0;
            core_ld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_win;
                        core_key  <= w_win_key;
                        core_text <= w_win_text;
                        gnt       <= w_win_oh;
                        core_ld   <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the expiry cycle still counts as success.
                    if (core_done) begin
                        rsp_data  <= core_text_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= w_own_oh;
                        r_state   <= S_RESP;
                    end else if (w_expire) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= w_own_oh;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (|(rsp_ack & w_own_oh)) begin
                        r_ptr     <= w_next_ptr;
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
